out_camera_data: RTL and testbench

- Camera-side transmitter for the LVAL/FVAL/DVAL + dual-tap pixel interface consumed by the camera input stage.
- Generates frame, line and data-valid timing from parameters and drives synthetic test-pattern pixels on the L/R taps.
- Used as an on-chip camera emulator for bring-up and loopback, and as the stimulus source in system simulation.

---
 rtl/out_camera_data_if.sv | 13 +
 rtl/out_camera_data.sv | 246 ++++++++++++++++++++++++
 tb/tb_out_camera_data.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/out_camera_data_if.sv
// Camera pixel bus: frame/line/data valid strobes plus left and right pixel taps.
interface out_camera_data_if #(
   parameter int PIXEL_WIDTH = 8
);
   logic                   oLVAL;
   logic                   oFVAL;
   logic                   oDVAL;
   logic [PIXEL_WIDTH-1:0] oDATA_L;
   logic [PIXEL_WIDTH-1:0] oDATA_R;

   modport master (output oLVAL, oFVAL, oDVAL, oDATA_L, oDATA_R);
   modport slave  (input  oLVAL, oFVAL, oDVAL, oDATA_L, oDATA_R);
endinterface

// File: rtl/out_camera_data.sv
// Camera emulator: parameterised FVAL/LVAL/DVAL timing with dual-tap test patterns.
// Define OUT_CAMERA_DVAL_THROTTLE_EN for DVAL on alternate clocks inside each line.
module out_camera_data #(
   parameter int PIXEL_WIDTH = 8,
   parameter int H_ACTIVE    = 640,
   parameter int H_BLANK     = 160,
   parameter int V_ACTIVE    = 480,
   parameter int FV_SETUP    = 4,
   parameter int V_BLANK     = 2000
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 iENABLE,
   input  logic                 iLVAL_POL,
   input  logic                 iFVAL_POL,
   input  logic                 iDVAL_POL,
   input  logic [1:0]           iPATTERN,
   out_camera_data_if.master    cam,
   output logic                 oFIELD,
   output logic [15:0]          oFRAME_CNT,
   output logic                 oBUSY
);

   localparam int XW   = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
   localparam int YW   = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
   localparam int CMAX = (FV_SETUP > H_BLANK) ? ((FV_SETUP > V_BLANK) ? FV_SETUP : V_BLANK)
                                              : ((H_BLANK > V_BLANK) ? H_BLANK : V_BLANK);
   localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
   localparam int EW   = (PIXEL_WIDTH > 4) ? PIXEL_WIDTH : 4;

   localparam logic [XW-1:0] X_LAST  = XW'(H_ACTIVE - 1);
   localparam logic [YW-1:0] Y_LAST  = YW'(V_ACTIVE - 1);
   localparam logic [CW-1:0] FS_LAST = CW'(FV_SETUP - 1);
   localparam logic [CW-1:0] HB_LAST = CW'(H_BLANK - 1);
   localparam logic [CW-1:0] VB_LAST = CW'(V_BLANK - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FV_LEAD,
      S_LINE,
      S_HBLANK,
      S_VBLANK
   } state_e;

   state_e                 state_q, state_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [XW-1:0]          x_q, x_d;
   logic [YW-1:0]          y_q, y_d;
   logic [1:0]             pattern_q, pattern_d;
   logic                   field_q, field_d;
   logic [15:0]            frame_cnt_q, frame_cnt_d;
   logic                   lval_q, lval_d;
   logic                   fval_q, fval_d;
   logic                   dval_q, dval_d;
   logic                   busy_q, busy_d;
   logic [PIXEL_WIDTH-1:0] data_l_q, data_l_d;
   logic [PIXEL_WIDTH-1:0] data_r_q, data_r_d;
`ifdef OUT_CAMERA_DVAL_THROTTLE_EN
   logic                   phase_q, phase_d;
`endif

   logic                   fval_i, lval_i, dval_i;
   logic [EW-1:0]          x_ext, y_ext;
   logic [PIXEL_WIDTH-1:0] fc_pix;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      x_d         = x_q;
      y_d         = y_q;
      pattern_d   = pattern_q;
      field_d     = field_q;
      frame_cnt_d = frame_cnt_q;
`ifdef OUT_CAMERA_DVAL_THROTTLE_EN
      phase_d     = phase_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (iENABLE) begin
               state_d   = S_FV_LEAD;
               cnt_d     = '0;
               y_d       = '0;
               pattern_d = iPATTERN;
            end
         end
         S_FV_LEAD: begin
            if (cnt_q == FS_LAST) begin
               state_d = S_LINE;
               cnt_d   = '0;
               x_d     = '0;
               y_d     = '0;
`ifdef OUT_CAMERA_DVAL_THROTTLE_EN
               phase_d = 1'b0;
`endif
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_LINE: begin
`ifdef OUT_CAMERA_DVAL_THROTTLE_EN
            // phase 0 is the DVAL clock for pixel x; phase 1 idles before advancing x
            if (!phase_q) begin
               phase_d = 1'b1;
            end else begin
               phase_d = 1'b0;
               if (x_q == X_LAST) begin
                  state_d = S_HBLANK;
                  cnt_d   = '0;
               end else begin
                  x_d = x_q + 1'b1;
               end
            end
`else
            if (x_q == X_LAST) begin
               state_d = S_HBLANK;
               cnt_d   = '0;
            end else begin
               x_d = x_q + 1'b1;
            end
`endif
         end
         S_HBLANK: begin
            if (cnt_q == HB_LAST) begin
               cnt_d = '0;
               if (y_q == Y_LAST) begin
                  state_d     = S_VBLANK;
                  field_d     = ~field_q;
                  frame_cnt_d = frame_cnt_q + 16'd1;
               end else begin
                  state_d = S_LINE;
                  y_d     = y_q + 1'b1;
                  x_d     = '0;
`ifdef OUT_CAMERA_DVAL_THROTTLE_EN
                  phase_d = 1'b0;
`endif
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_VBLANK: begin
            if (cnt_q == VB_LAST) begin
               cnt_d = '0;
               if (iENABLE) begin
                  state_d   = S_FV_LEAD;
                  y_d       = '0;
                  pattern_d = iPATTERN;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs are decoded from the next state so the registered pins line up with state_q.
   always_comb begin
      fval_i = (state_d != S_IDLE) && (state_d != S_VBLANK);
      lval_i = (state_d == S_LINE);
`ifdef OUT_CAMERA_DVAL_THROTTLE_EN
      dval_i = lval_i && !phase_d;
`else
      dval_i = lval_i;
`endif
      x_ext    = EW'(x_d);
      y_ext    = EW'(y_d);
      fc_pix   = PIXEL_WIDTH'(frame_cnt_q);
      data_l_d = '0;
      data_r_d = '0;
      if (dval_i) begin
         case (pattern_d)
            2'd0: begin
               data_l_d = x_ext[PIXEL_WIDTH-1:0];
               data_r_d = ~x_ext[PIXEL_WIDTH-1:0];
            end
            2'd1: begin
               data_l_d = y_ext[PIXEL_WIDTH-1:0];
               data_r_d = ~y_ext[PIXEL_WIDTH-1:0];
            end
            2'd2: begin
               data_l_d = {PIXEL_WIDTH{x_ext[3] ^ y_ext[3]}};
               data_r_d = {PIXEL_WIDTH{x_ext[3] ^ y_ext[3]}};
            end
            default: begin
               data_l_d = fc_pix;
               data_r_d = fc_pix;
            end
         endcase
      end
      lval_d = lval_i ^ iLVAL_POL;
      fval_d = fval_i ^ iFVAL_POL;
      dval_d = dval_i ^ iDVAL_POL;
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         x_q         <= '0;
         y_q         <= '0;
         pattern_q   <= '0;
         field_q     <= 1'b0;
         frame_cnt_q <= '0;
         lval_q      <= iLVAL_POL;
         fval_q      <= iFVAL_POL;
         dval_q      <= iDVAL_POL;
         busy_q      <= 1'b0;
         data_l_q    <= '0;
         data_r_q    <= '0;
`ifdef OUT_CAMERA_DVAL_THROTTLE_EN
         phase_q     <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         x_q         <= x_d;
         y_q         <= y_d;
         pattern_q   <= pattern_d;
         field_q     <= field_d;
         frame_cnt_q <= frame_cnt_d;
         lval_q      <= lval_d;
         fval_q      <= fval_d;
         dval_q      <= dval_d;
         busy_q      <= busy_d;
         data_l_q    <= data_l_d;
         data_r_q    <= data_r_d;
`ifdef OUT_CAMERA_DVAL_THROTTLE_EN
         phase_q     <= phase_d;
`endif
      end
   end

   assign cam.oLVAL   = lval_q;
   assign cam.oFVAL   = fval_q;
   assign cam.oDVAL   = dval_q;
   assign cam.oDATA_L = data_l_q;
   assign cam.oDATA_R = data_r_q;
   assign oFIELD      = field_q;
   assign oFRAME_CNT  = frame_cnt_q;
   assign oBUSY       = busy_q;

endmodule

// File: tb/tb_out_camera_data.sv
// Bench for out_camera_data: frame-position reference model, vector table, corner sequences, random run.
module tb_out_camera_data;
   localparam int PW = 8, H = 4, HB = 2, V = 3, FS = 2, VB = 5;
`ifdef OUT_CAMERA_DVAL_THROTTLE_EN
   localparam bit THR = 1'b1;
`else
   localparam bit THR = 1'b0;
`endif
   localparam int LL     = THR ? 2 * H : H;
   localparam int LP     = LL + HB;
   localparam int FV_LEN = FS + V * LP;
   localparam int PERIOD = FV_LEN + VB;
   localparam int PMAX   = (1 << PW) - 1;

   logic clk = 1'b0, rst = 1'b1, en = 1'b0, lpol = 1'b0, fpol = 1'b0, dpol = 1'b0;
   logic [1:0]  pat = 2'd0;
   logic        field, busy;
   logic [15:0] fcnt;

   out_camera_data_if #(.PIXEL_WIDTH(PW)) cam_if ();

   out_camera_data #(
      .PIXEL_WIDTH(PW), .H_ACTIVE(H), .H_BLANK(HB), .V_ACTIVE(V), .FV_SETUP(FS), .V_BLANK(VB)
   ) dut (
      .CLK(clk), .RST(rst), .iENABLE(en), .iLVAL_POL(lpol), .iFVAL_POL(fpol), .iDVAL_POL(dpol),
      .iPATTERN(pat), .cam(cam_if), .oFIELD(field), .oFRAME_CNT(fcnt), .oBUSY(busy)
   );

   always #5 clk = ~clk;

   int total = 0, bad = 0;

   // Reference model: position within the frame period, -1 when idle.
   int       m_pos = -1, m_frames = 0;
   bit       m_field = 1'b0;
   bit [1:0] m_pat = 2'd0;
   bit       e_fv, e_lv, e_dv;
   int       e_l, e_r;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_step();
      int q, p, x, y;
      if (rst) begin
         m_pos = -1; m_frames = 0; m_field = 1'b0;
      end else if (m_pos < 0 || m_pos == PERIOD - 1) begin
         if (en) begin m_pos = 0; m_pat = pat; end
         else m_pos = -1;
      end else begin
         m_pos++;
         if (m_pos == FV_LEN) begin
            m_frames = (m_frames + 1) % 65536;
            m_field  = !m_field;
         end
      end
      e_fv = (m_pos >= 0) && (m_pos < FV_LEN);
      e_lv = 1'b0; e_dv = 1'b0; e_l = 0; e_r = 0;
      if (m_pos >= FS && m_pos < FV_LEN) begin
         q = m_pos - FS; y = q / LP; p = q % LP;
         if (p < LL) begin
            e_lv = 1'b1;
            e_dv = THR ? (p % 2 == 0) : 1'b1;
            x    = THR ? p / 2 : p;
            if (e_dv) begin
               case (m_pat)
                  2'd0: begin e_l = x % (PMAX + 1); e_r = PMAX - e_l; end
                  2'd1: begin e_l = y % (PMAX + 1); e_r = PMAX - e_l; end
                  2'd2: begin e_l = ((((x >> 3) ^ (y >> 3)) & 1) != 0) ? PMAX : 0; e_r = e_l; end
                  default: begin e_l = m_frames % (PMAX + 1); e_r = e_l; end
               endcase
            end
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      chk("oFVAL",      32'(cam_if.oFVAL),   32'(e_fv ^ fpol));
      chk("oLVAL",      32'(cam_if.oLVAL),   32'(e_lv ^ lpol));
      chk("oDVAL",      32'(cam_if.oDVAL),   32'(e_dv ^ dpol));
      chk("oDATA_L",    32'(cam_if.oDATA_L), e_l);
      chk("oDATA_R",    32'(cam_if.oDATA_R), e_r);
      chk("oFIELD",     32'(field),          32'(m_field));
      chk("oFRAME_CNT", 32'(fcnt),           m_frames);
      chk("oBUSY",      32'(busy),           32'(m_pos >= 0));
   endtask

   task automatic do_reset();
      rst = 1'b1; en = 1'b0;
      tick(); tick();
      rst = 1'b0;
   endtask

   typedef struct {
      int ncyc; bit en; bit pol; bit [1:0] pat;
      int fv_hi; int lv_hi; int dv_hi; int l_sum; int r_sum; int frames; bit fld;
   } vec_t;

   vec_t vecs[6];

   initial begin
      int fvh, lvh, dvh, ls, rs, n;
`ifdef OUT_CAMERA_DVAL_THROTTLE_EN
      vecs[0] = '{74, 1'b1, 1'b0, 2'd0, 64, 48, 24, 36, 6084, 2, 1'b0};
      vecs[1] = '{30, 1'b0, 1'b0, 2'd0,  0,  0,  0,  0,    0, 0, 1'b0};
      vecs[2] = '{74, 1'b1, 1'b1, 2'd0, 10, 26, 50, 36, 6084, 2, 1'b0};
      vecs[3] = '{40, 1'b1, 1'b0, 2'd0, 35, 25, 13, 18, 3297, 1, 1'b1};
      vecs[4] = '{37, 1'b1, 1'b0, 2'd1, 32, 24, 12, 12, 3048, 1, 1'b1};
      vecs[5] = '{74, 1'b1, 1'b0, 2'd3, 64, 48, 24, 12,   12, 2, 1'b0};
`else
      vecs[0] = '{50, 1'b1, 1'b0, 2'd0, 40, 24, 24, 36, 6084, 2, 1'b0};
      vecs[1] = '{30, 1'b0, 1'b0, 2'd0,  0,  0,  0,  0,    0, 0, 1'b0};
      vecs[2] = '{50, 1'b1, 1'b1, 2'd0, 10, 26, 26, 36, 6084, 2, 1'b0};
      vecs[3] = '{30, 1'b1, 1'b0, 2'd0, 25, 15, 15, 21, 3804, 1, 1'b1};
      vecs[4] = '{25, 1'b1, 1'b0, 2'd1, 20, 12, 12, 12, 3048, 1, 1'b1};
      vecs[5] = '{50, 1'b1, 1'b0, 2'd3, 40, 24, 24, 12,   12, 2, 1'b0};
`endif

      for (int i = 0; i < 6; i++) begin
         pat = vecs[i].pat;
         {lpol, fpol, dpol} = {3{vecs[i].pol}};
         do_reset();
         en = vecs[i].en;
         fvh = 0; lvh = 0; dvh = 0; ls = 0; rs = 0;
         for (int c = 0; c < vecs[i].ncyc; c++) begin
            tick();
            fvh += int'(cam_if.oFVAL);
            lvh += int'(cam_if.oLVAL);
            dvh += int'(cam_if.oDVAL);
            ls  += int'(cam_if.oDATA_L);
            rs  += int'(cam_if.oDATA_R);
         end
         chk($sformatf("vec%0d_fval_hi", i), fvh, vecs[i].fv_hi);
         chk($sformatf("vec%0d_lval_hi", i), lvh, vecs[i].lv_hi);
         chk($sformatf("vec%0d_dval_hi", i), dvh, vecs[i].dv_hi);
         chk($sformatf("vec%0d_l_sum", i), ls, vecs[i].l_sum);
         chk($sformatf("vec%0d_r_sum", i), rs, vecs[i].r_sum);
         chk($sformatf("vec%0d_frames", i), 32'(fcnt), vecs[i].frames);
         chk($sformatf("vec%0d_field", i), 32'(field), 32'(vecs[i].fld));
      end

      // Enable dropped at the start of line 1: frame finishes, then idle.
      {lpol, fpol, dpol} = 3'b000; pat = 2'd0;
      do_reset();
      en = 1'b1; n = 0;
      repeat (FS + LP + 1) begin tick(); n++; end
      en = 1'b0;
      while (busy !== 1'b0 && n < 200) begin tick(); n++; end
      chk("drop_busy_fall_cycle", n, PERIOD + 1);
      chk("drop_frame_cnt", 32'(fcnt), 1);
      chk("drop_field", 32'(field), 1);
      fvh = 0;
      repeat (40) begin tick(); fvh += int'(cam_if.oFVAL); end
      chk("drop_no_more_fval", fvh, 0);

      // Reset mid line 1, then a clean restart.
      do_reset();
      en = 1'b1;
      repeat (FS + LP + 2) tick();
      rst = 1'b1;
      tick();
      chk("rst_mid_fval", 32'(cam_if.oFVAL), 0);
      chk("rst_mid_lval", 32'(cam_if.oLVAL), 0);
      chk("rst_mid_dval", 32'(cam_if.oDVAL), 0);
      chk("rst_mid_data_l", 32'(cam_if.oDATA_L), 0);
      chk("rst_mid_data_r", 32'(cam_if.oDATA_R), 0);
      chk("rst_mid_frame_cnt", 32'(fcnt), 0);
      chk("rst_mid_field", 32'(field), 0);
      chk("rst_mid_busy", 32'(busy), 0);
      rst = 1'b0;
      fvh = 0; lvh = 0;
      repeat (PERIOD) begin
         tick();
         fvh += int'(cam_if.oFVAL);
         lvh += int'(cam_if.oLVAL);
      end
      chk("restart_fval_hi", fvh, FV_LEN);
      chk("restart_lval_hi", lvh, V * LL);
      chk("restart_frame_cnt", 32'(fcnt), 1);

      // Random run against the model.
      for (int c = 0; c < 4000; c++) begin
         en  = ($urandom_range(0, 99) < 85);
         pat = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 499) == 0) {lpol, fpol, dpol} = 3'($urandom_range(0, 7));
         rst = ($urandom_range(0, 699) == 0);
         tick();
      end
      rst = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
